// File: rtl/ballot_pkg.sv
// Shared types and sizing for the ballot controller and its button front end.
package ballot_pkg;

  localparam int unsigned NUM_CANDIDATES = 4;
  localparam int unsigned CAST_WIDTH     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCast,
    StLockout
  } ballot_state_e;

endpackage

// File: rtl/ballot_controller_if.sv
// Voting-booth signal bundle: officer/voter inputs and vote/status outputs.
interface ballot_controller_if;

  logic                                 mode;
  logic [ballot_pkg::NUM_CANDIDATES-1:0] button;
  logic                                 ballot_enable;
  logic [ballot_pkg::NUM_CANDIDATES-1:0] candidate_valid_vote;
  logic                                 ballot_ready;
  logic                                 ballot_expired;
  logic [ballot_pkg::CAST_WIDTH-1:0]     ballots_cast;

  modport master (
    output mode, button, ballot_enable,
    input  candidate_valid_vote, ballot_ready, ballot_expired, ballots_cast
  );

  modport slave (
    input  mode, button, ballot_enable,
    output candidate_valid_vote, ballot_ready, ballot_expired, ballots_cast
  );

endinterface

// File: rtl/ballot_controller_button_debounce.sv
// One candidate button: 2-flop synchronizer, stability filter and rising-edge press pulse.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic button_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter tracks consecutive samples that disagree with the filtered level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/ballot_controller.sv
// Ballot controller: issues one ballot per officer enable and records a single debounced vote.
module ballot_controller
  import ballot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input logic                clock,
  input logic                reset,
  ballot_controller_if.slave bus
);

  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_CANDIDATES-1:0] level, press;
  ballot_state_e             state_q, state_d;
  logic [TmrW-1:0]           tmr_q, tmr_d;
  logic [NUM_CANDIDATES-1:0] vote_q, vote_d;
  logic                      expired_q, expired_d;
  logic [CAST_WIDTH-1:0]     cast_q, cast_d;

  for (genvar i = 0; i < NUM_CANDIDATES; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock   (clock),
      .reset   (reset),
      .button_i(bus.button[i]),
      .level_o (level[i]),
      .press_o (press[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    vote_d    = '0;
    expired_d = 1'b0;
    cast_d    = cast_q;
    unique case (state_q)
      StIdle: begin
        if (bus.ballot_enable && !bus.mode) begin
          state_d = StArmed;
          tmr_d   = '0;
        end
      end
      // Priority: result mode cancels, then a single press votes, then timeout.
      StArmed: begin
        if (bus.mode) begin
          state_d = StIdle;
        end else if ($countones(press) == 1) begin
          state_d = StCast;
          vote_d  = press;
          cast_d  = cast_q + CAST_WIDTH'(1);
        end else if (tmr_q == TmrW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StIdle;
          expired_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StCast:    state_d = StLockout;
      StLockout: if (level == '0) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      tmr_q     <= '0;
      vote_q    <= '0;
      expired_q <= 1'b0;
      cast_q    <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      vote_q    <= vote_d;
      expired_q <= expired_d;
      cast_q    <= cast_d;
    end
  end

  assign bus.candidate_valid_vote = vote_q;
  assign bus.ballot_ready         = (state_q == StArmed);
  assign bus.ballot_expired       = expired_q;
  assign bus.ballots_cast         = cast_q;

endmodule

// File: doc/ballot_controller.md
BALLOT_CONTROLLER -- requirements
Module: ballot_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a press or release.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum cycles a ballot stays armed without a vote.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mode  input  1  0 = voting mode; 1 = result mode, in which no ballot is issued or cast.
REQ-006 button  input  4  raw asynchronous candidate buttons; bit i (1..4) is candidate i.
REQ-007 ballot_enable  input  1  single-cycle pulse from the presiding officer that issues one ballot.
REQ-008 candidate_valid_vote  output  4  registered one-hot, single-cycle pulse naming the voted candidate.
REQ-009 ballot_ready  output  1  high while a ballot is armed and awaiting a press.
REQ-010 ballot_expired  output  1  registered single-cycle pulse when an armed ballot times out.
REQ-011 ballots_cast  output  8  count of votes emitted, wrapping 255->0.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose filtered level changes only after DEBOUNCE_CYCLES consecutive synchronized samples at the new level.
REQ-013 A press event SHALL be a one-cycle pulse on a filtered 0->1 transition; at most one event per physical press.
REQ-014 FSM states are IDLE, ARMED, CAST and LOCKOUT.
REQ-015 IDLE->ARMED on ballot_enable=1 with mode=0; ballot_enable is ignored in all other states or when mode=1.
REQ-016 ARMED with exactly one press event SHALL go to CAST; the event index is latched.
REQ-017 ARMED with two or more simultaneous press events SHALL ignore them all and remain ARMED.
REQ-018 CAST lasts one cycle: candidate_valid_vote = latched one-hot, ballots_cast increments, next state LOCKOUT.
REQ-019 Latency: a press event at cycle n gives candidate_valid_vote high during cycle n+1 only.
REQ-020 LOCKOUT->IDLE once all four filtered levels are 0, so a held button cannot vote twice.
REQ-021 ARMED SHALL count cycles from entry; when the count reaches TIMEOUT_CYCLES with no vote, the FSM goes to IDLE and pulses ballot_expired for one cycle.
REQ-022 mode=1 while ARMED SHALL return the FSM to IDLE next cycle with no vote and no expired pulse.
REQ-023 A press event in IDLE or LOCKOUT SHALL be discarded and never queued.
REQ-024 ballot_ready = (state==ARMED); candidate_valid_vote = 0 outside CAST.
REQ-025 Press event and timeout in the same ARMED cycle: the vote wins and ballot_expired stays 0.

Reset
REQ-026 Reset SHALL force state IDLE, synchronizers, debounce counters and filtered levels to 0, and all outputs to 0.
REQ-027 Reset mid-ballot (ARMED, CAST or LOCKOUT) SHALL emit no vote pulse in the reset cycle or after it.

Structure
REQ-028 A shared ballot_pkg SHALL hold the FSM state encoding, NUM_CANDIDATES=4 and the ballots_cast width.
REQ-029 A sub-module button_debounce (synchronizer, debounce counter and press-event pulse) SHALL be instantiated four times.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50)
REQ-030 ballot_enable, then button[2] held 10 cycles and released -> candidate_valid_vote=4'b0010 for exactly 1 cycle, ballots_cast=1, return to IDLE after debounced release.
REQ-031 button[3] held continuously across two ballot_enable pulses -> exactly one vote; the second ballot is not issued until after release.
REQ-032 button[1] and button[4] asserted in the same cycle while ARMED -> no vote and ballot_ready stays 1; a later button[4] alone -> 4'b1000.
REQ-033 ballot_enable with no press -> ballot_expired pulses once 50 cycles after ARMED entry, and the FSM returns to IDLE.
REQ-034 A 2-cycle glitch on button[1] while ARMED -> no vote; mode=1 during ARMED -> IDLE, no vote, no expired pulse.
REQ-035 256 complete ballots -> ballots_cast wraps to 0; reset asserted in LOCKOUT -> all outputs 0 and no pulse.
